mips_alu_multicycle: RTL and testbench
======================================

MIPS_ALU_MULTICYCLE -- requirements
Module: mips_alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port alu_op, input, 3 bits: opcode per REQ-011.
REQ-007 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the result handshake.
REQ-009 The block SHALL have ports result and result_hi, outputs, WIDTH bits each: result_hi holds the MUL upper word or the DIV remainder, and is 0 for all other ops.
REQ-010 The block SHALL have flag outputs zero, ovf, cout, dz and err, 1 bit each.

Function
REQ-011 Opcodes SHALL be:
- 000 AND: a&b
- 001 OR: a|b
- 010 ADD: a+b
- 110 SUB: a-b
- 111 SLT: 1 if signed(a)<signed(b), else 0
- 011 MULU: unsigned 2*WIDTH-bit product
- 100 DIVU: unsigned quotient and remainder
- 101: illegal
REQ-012 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b and alu_op SHALL be captured at that edge.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Transitions SHALL be:
- IDLE->DONE on accept of a single-cycle op, DIVU with b==0, or an illegal op.
- IDLE->BUSY on accept of MULU or DIVU with b!=0.
- BUSY->DONE after exactly WIDTH iteration cycles.
- DONE->IDLE when out_ready is 1.
REQ-015 out_valid SHALL be 1 only in DONE. Single-cycle latency: out_valid rises 1 cycle after accept. MULU/DIVU latency: out_valid rises WIDTH+1 cycles after accept.
REQ-016 All outputs SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-017 ADD/SUB SHALL compute a+b and a+~b+1 respectively; cout is the carry out of bit WIDTH-1 (SUB: 1 means no borrow); ovf is signed overflow. Both flags SHALL be 0 for all other ops.
REQ-018 zero SHALL be 1 when result==0 and result_hi==0.
REQ-019 MULU SHALL use iterative shift-add, one multiplier bit per cycle: result is the low word, result_hi the high word.
REQ-020 DIVU SHALL use restoring shift-subtract, one quotient bit per cycle: result is the quotient, result_hi the remainder.
REQ-021 DIVU with b==0 SHALL give result all-ones, result_hi=a and dz=1, with single-cycle latency.
REQ-022 An illegal opcode SHALL give result=0, result_hi=0, err=1 and all other flags 0, with single-cycle latency.
REQ-023 in_valid asserted while not in IDLE SHALL be ignored; operands SHALL NOT be re-sampled.

Reset
REQ-024 While rst_n=0, the state SHALL be IDLE, out_valid=0, in_ready=1 once released, and result, result_hi and all flags SHALL be 0.
REQ-025 Reset asserted during BUSY or DONE SHALL abort the operation immediately; no result is ever delivered for it.
REQ-026 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Package mips_alu_pkg SHALL hold the opcode constants (OP_AND, OP_OR, OP_ADD, OP_MULU, OP_DIVU, OP_SUB, OP_SLT) and the FSM state enum.
REQ-028 The iterative datapath SHALL be sub-module mips_alu_muldiv (parameter WIDTH), with a start/done interface, an iteration counter, and a shared accumulator/shift register.
REQ-029 Single-cycle ops SHALL be computed combinationally from the captured operands and registered into the outputs on the IDLE->DONE edge.

Verification (WIDTH=32)
REQ-030 ADD a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE, cout=1, ovf=0, zero=0, out_valid 1 cycle after accept.
REQ-031 SUB a=0x80000000, b=0x7FFFFFFF -> result=0x00000001, ovf=1, cout=1. SUB a=4, b=10 -> result=0xFFFFFFFA, cout=0.
REQ-032 MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result=0x00000001; out_valid exactly 33 cycles after accept; in_ready=0 throughout; in_valid pulses during BUSY are ignored.
REQ-033 DIVU a=100, b=7 -> result=14, result_hi=2. DIVU a=5, b=0 -> result=0xFFFFFFFF, result_hi=5, dz=1, latency 1.
REQ-034 SLT a=0x00000000, b=0xFFFFFFFF -> result=0. Opcode 101 -> err=1, result=0. With out_ready held 0 for 5 cycles, all outputs stay stable; accept occurs only after the handshake completes.
REQ-035 rst_n pulsed low at cycle 10 of a MULU -> out_valid stays 0 and in_ready=1 after release; the next ADD 2+3 returns 5.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared opcode constants and FSM state type for the multi-cycle ALU.
// No ports; imported by mips_alu_muldiv and mips_alu_multicycle.
package mips_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_ILL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } alu_state_e;

endpackage

// File: rtl/mips_alu_muldiv.sv
// mips_alu_muldiv: iterative unsigned multiplier (shift-add) and divider (restoring
// shift-subtract), one bit per cycle, WIDTH cycles per operation.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         load operands and begin (is_div selects divide, else multiply)
//   a, b          multiplier/dividend and multiplicand/divisor
//   done          high during the final iteration cycle
//   lo, hi        value the accumulator takes at the end of this cycle; on done this is
//                 the product (hi:lo) or quotient (lo) and remainder (hi)
module mips_alu_muldiv
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             busy_q;
    logic             div_q;
    logic [CntW-1:0]  cnt_q;
    // hi_q:lo_q is the shared accumulator/shift register; lo_q starts as a and is shifted
    // out as result bits are shifted in.
    logic [WIDTH-1:0] hi_q, lo_q, dvs_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   shifted, diff, sum;

    always_comb begin
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        if (div_q) begin
            // Partial remainder stays below the divisor, so a clear MSB means no borrow.
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == CntW'(WIDTH - 1));
    assign lo   = lo_d;
    assign hi   = hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a;
            dvs_q  <= b;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_alu_multicycle.sv
// mips_alu_multicycle: MIPS-style ALU with valid/ready handshakes. Logic and add/sub/slt
// ops, DIVU by zero and illegal opcodes finish one cycle after accept; MULU and DIVU run
// on the iterative mips_alu_muldiv and finish WIDTH+1 cycles after accept.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid, in_ready       request handshake (ready only when idle)
//   alu_op, a, b             opcode and operands, captured on accept
//   out_valid, out_ready     result handshake (valid only when done)
//   result, result_hi        low word / quotient, and high word / remainder
//   zero, ovf, cout, dz, err result flags
module mips_alu_multicycle
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             cout,
    output logic             dz,
    output logic             err
);

    alu_state_e state_q, state_d;
    logic       load_sc, load_md;
    logic       is_iter, md_start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_ovf, sc_cout, sc_dz, sc_err;

    assign is_iter  = (alu_op == OP_MULU) || ((alu_op == OP_DIVU) && (b != '0));
    assign md_start = (state_q == StIdle) && in_valid && is_iter;

    mips_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .is_div(alu_op == OP_DIVU),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle results, registered only on the IDLE->DONE edge.
    always_comb begin
        sc_res  = '0;
        sc_hi   = '0;
        sc_ovf  = 1'b0;
        sc_cout = 1'b0;
        sc_dz   = 1'b0;
        sc_err  = 1'b0;
        case (alu_op)
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_ADD: begin
                sc_res  = add_sum[WIDTH-1:0];
                sc_cout = add_sum[WIDTH];
                sc_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res  = sub_sum[WIDTH-1:0];
                sc_cout = sub_sum[WIDTH];
                sc_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
            // Only reaches the outputs when b is zero; otherwise the iterative path runs.
            OP_DIVU: begin
                sc_res = '1;
                sc_hi  = a;
                sc_dz  = 1'b1;
            end
            OP_MULU: sc_res = '0;
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load_sc = 1'b0;
        load_md = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_iter) begin
                        state_d = StBusy;
                    end else begin
                        state_d = StDone;
                        load_sc = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (md_done) begin
                    state_d = StDone;
                    load_md = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            cout      <= 1'b0;
            dz        <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_sc) begin
                result    <= sc_res;
                result_hi <= sc_hi;
                // An illegal op reports only err, even though its result words are zero.
                zero      <= (sc_res == '0) && (sc_hi == '0) && !sc_err;
                ovf       <= sc_ovf;
                cout      <= sc_cout;
                dz        <= sc_dz;
                err       <= sc_err;
            end else if (load_md) begin
                result    <= md_lo;
                result_hi <= md_hi;
                zero      <= (md_lo == '0) && (md_hi == '0);
                ovf       <= 1'b0;
                cout      <= 1'b0;
                dz        <= 1'b0;
                err       <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_mips_alu_multicycle.sv
// tb_mips_alu_multicycle: directed vector table, hand-written handshake/reset sequences
// and random operations checked against an arithmetic reference model.
module tb_mips_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   alu_op = 3'b000;
    logic [W-1:0] a = '0, b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result, result_hi;
    logic         zero, ovf, cout, dz, err;

    int n_cmp = 0;
    int n_err = 0;

    mips_alu_multicycle #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .result_hi(result_hi),
        .zero     (zero),
        .ovf      (ovf),
        .cout     (cout),
        .dz       (dz),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero, ovf, cout, dz, err;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        vec_t        e;
        longint      sx, sy, s;
        logic [63:0] wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = '{op: op, a: x, b: y, res: '0, hi: '0, zero: 0, ovf: 0, cout: 0, dz: 0, err: 0,
              lat: 1};
        case (op)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: begin
                wide   = {32'b0, x} + {32'b0, y};
                e.res  = wide[31:0];
                e.cout = wide[32];
                s      = sx + sy;
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                e.res  = x - y;
                e.cout = (x >= y);
                s      = sx - sy;
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111: e.res = (sx < sy) ? 32'd1 : 32'd0;
            3'b011: begin
                wide  = {32'b0, x} * {32'b0, y};
                e.res = wide[31:0];
                e.hi  = wide[63:32];
                e.lat = W + 1;
            end
            3'b100: begin
                if (y == 0) begin
                    e.res = '1;
                    e.hi  = x;
                    e.dz  = 1'b1;
                end else begin
                    e.res = x / y;
                    e.hi  = x % y;
                    e.lat = W + 1;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 0) && (e.hi == 0) && !e.err;
        return e;
    endfunction

    task automatic chk_out(input string name, input vec_t e);
        chk({name, ".result"}, 64'(result), 64'(e.res));
        chk({name, ".result_hi"}, 64'(result_hi), 64'(e.hi));
        chk({name, ".flags(z,o,c,dz,err)"}, 64'({zero, ovf, cout, dz, err}),
            64'({e.zero, e.ovf, e.cout, e.dz, e.err}));
    endtask

    // Issue one op (DUT assumed idle), measure latency, hold out_ready low for
    // hold cycles while poking in_valid, then complete the handshake.
    task automatic do_op(input string name, input vec_t e, input int hold, input bit poke);
        int lat;
        in_valid = 1'b1;
        alu_op   = e.op;
        a        = e.a;
        b        = e.b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            if (poke) begin
                in_valid = 1'b1;
                alu_op   = 3'($urandom);
                chk({name, ".in_ready_busy"}, 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({name, ".latency"}, 64'(lat), 64'(e.lat));
        chk_out(name, e);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            alu_op   = 3'($urandom);
            @(posedge clk);
            #1;
            chk({name, ".hold_valid"}, 64'({out_valid, in_ready}), 64'b10);
            chk_out({name, ".hold"}, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, ".release"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    vec_t vecs[15];
    vec_t e;

    initial begin
        vecs[0]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 0, 1};
        vecs[1]  = '{3'b110, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 1, 1, 0, 0, 1};
        vecs[2]  = '{3'b110, 32'd4, 32'd10, 32'hFFFFFFFA, 0, 0, 0, 0, 0, 0, 1};
        vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 33};
        vecs[4]  = '{3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 0, 0, 33};
        vecs[5]  = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0, 0, 0, 1, 0, 1};
        vecs[6]  = '{3'b111, 32'h0, 32'hFFFFFFFF, 32'h0, 0, 1, 0, 0, 0, 0, 1};
        vecs[7]  = '{3'b101, 32'h1234, 32'h5678, 32'h0, 0, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0, 0, 0, 1};
        vecs[9]  = '{3'b001, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 0, 1};
        vecs[10] = '{3'b010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 0, 0, 0, 1};
        vecs[11] = '{3'b110, 32'd5, 32'd5, 32'h0, 0, 1, 0, 1, 0, 0, 1};
        vecs[12] = '{3'b111, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 0, 0, 0, 0, 0, 1};
        vecs[13] = '{3'b100, 32'd3, 32'd10, 32'h0, 32'd3, 0, 0, 0, 0, 0, 33};
        vecs[14] = '{3'b011, 32'h0, 32'd5, 32'h0, 32'h0, 1, 0, 0, 0, 0, 33};

        // Reset state.
        #12;
        chk("reset.valid_ready", 64'({out_valid, in_ready}), 64'b01);
        chk("reset.outputs", 64'({result, zero, ovf, cout, dz, err}), 64'd0);
        chk("reset.result_hi", 64'(result_hi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; first op accepted on the first edge after reset release.
        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
        end

        // MULU with in_valid pulses during BUSY, then 5-cycle output stall.
        do_op("mulu_poke", model(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF), 5, 1'b1);
        do_op("illegal_hold", model(3'b101, 32'hABCD, 32'h1), 5, 1'b0);

        // Reset at cycle 10 of a MULU aborts it.
        in_valid = 1'b1;
        alu_op   = 3'b011;
        a        = 32'd12345;
        b        = 32'd678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("abort.during_reset", 64'({out_valid, result, result_hi}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                seen |= out_valid;
            end
            chk("abort.no_result", 64'(seen), 64'd0);
        end
        do_op("after_abort_add", model(3'b010, 32'd2, 32'd3), 0, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]   op;
            logic [W-1:0] x, y;
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = 32'($urandom_range(1, 15));
                2: x = 32'h80000000 ^ 32'($urandom_range(0, 3));
                default: ;
            endcase
            e = model(op, x, y);
            do_op($sformatf("rand%0d", i), e, $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
